// File: rtl/fft_inplace_sequencer_pkg.sv
// fft_inplace_sequencer_pkg: defaults, state encoding and index helpers for the FFT sequencer
package fft_inplace_sequencer_pkg;
  localparam int LOG2N_DEF = 5;
  localparam int PIPE_LAT_DEF = 2;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_COMP = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_OUT = 3'd4;
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int n);
    logic [15:0] r, t;
    r = '0;
    t = v;
    for (int i = 0; i < 16; i++)
      if (i < n) begin
        r = {r[14:0], t[0]};
        t = t >> 1;
      end
    return r;
  endfunction
  function automatic logic parity(input logic [15:0] v);
    return ^v;
  endfunction
  function automatic logic [15:0] ins0(input logic [15:0] v, input int s);
    logic [15:0] m;
    m = (16'd1 << s) - 16'd1;
    return ((v & ~m) << 1) | (v & m);
  endfunction
endpackage

// File: rtl/fft_wb_delay.sv
// fft_wb_delay: DEPTH-stage shift register carrying butterfly write-back controls
module fft_wb_delay #(
  parameter int W = 1,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst,
  input logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] sr [DEPTH];
  always_ff @(posedge clk)
    if (rst) sr <= '{default: '0};
    else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/fft_inplace_sequencer.sv
// fft_inplace_sequencer: load/butterfly/readout address sequencer for a two-bank in-place radix-2 FFT
module fft_inplace_sequencer
  import fft_inplace_sequencer_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF,
  parameter int ADDR_W = LOG2N - 1,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic valid,
  output logic busy,
  output logic load_done,
  output logic load_bank,
  output logic we_b0,
  output logic we_b1,
  output logic re_b0,
  output logic re_b1,
  output logic [ADDR_W-1:0] waddr_b0,
  output logic [ADDR_W-1:0] waddr_b1,
  output logic [ADDR_W-1:0] raddr_b0,
  output logic [ADDR_W-1:0] raddr_b1,
  output logic swap_rd,
  output logic swap_wr,
  output logic [LOG2N-2:0] tw_idx,
  output logic out_valid,
  output logic done
);
  localparam int N = 1 << LOG2N;
  localparam int H = N / 2;
  localparam int TW = LOG2N - 1;
  localparam int DW = $clog2(PIPE_LAT + 1);
  logic [2:0] state;
  logic [LOG2N-1:0] k, s;
  logic [ADDR_W-1:0] b, p, ld_addr, wb_a0, wb_a1;
  logic [DW-1:0] d;
  logic ld_we0, ld_we1, ld_fire, wb_we, comp, outp, pu;
  logic [15:0] u, l, j;
  always_comb begin
    comp = state == ST_COMP;
    outp = state == ST_OUT;
    ld_fire = state == ST_LOAD && valid;
    u = ins0(16'(b), int'(s));
    l = u | (16'd1 << s);
    pu = parity(u);
    j = bitrev(16'(k), LOG2N);
    busy = state != ST_IDLE;
    re_b0 = comp | outp;
    re_b1 = comp | outp;
    raddr_b0 = outp ? p : comp ? ADDR_W'((pu ? l : u) >> 1) : '0;
    raddr_b1 = outp ? p : comp ? ADDR_W'((pu ? u : l) >> 1) : '0;
    swap_rd = outp ? parity(16'(p)) : comp & pu;
    tw_idx = comp ? TW'((16'(b) & ((16'd1 << s) - 16'd1)) << (LOG2N - 1 - int'(s))) : '0;
    we_b0 = ld_we0 | wb_we;
    we_b1 = ld_we1 | wb_we;
    waddr_b0 = wb_we ? wb_a0 : ld_addr;
    waddr_b1 = wb_we ? wb_a1 : ld_addr;
  end
  fft_wb_delay #(.W(2 * ADDR_W + 2), .DEPTH(PIPE_LAT)) u_wb (
    .clk(clk),
    .rst(rst),
    .din({comp, raddr_b0, raddr_b1, swap_rd}),
    .dout({wb_we, wb_a0, wb_a1, swap_wr})
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      k <= '0;
      s <= '0;
      b <= '0;
      p <= '0;
      d <= '0;
      ld_we0 <= 1'b0;
      ld_we1 <= 1'b0;
      ld_addr <= '0;
      load_bank <= 1'b0;
      load_done <= 1'b0;
      out_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      ld_we0 <= ld_fire & ~parity(j);
      ld_we1 <= ld_fire & parity(j);
      ld_addr <= ld_fire ? ADDR_W'(j >> 1) : '0;
      load_bank <= ld_fire & parity(j);
      out_valid <= outp;
      done <= outp && p == ADDR_W'(H - 1);
      case (state)
        ST_IDLE:
          if (start) begin
            state <= ST_LOAD;
            k <= '0;
          end
        ST_LOAD:
          if (valid) begin
            k <= k + LOG2N'(1);
            if (k == LOG2N'(N - 1)) begin
              state <= ST_COMP;
              load_done <= 1'b1;
              s <= '0;
              b <= '0;
            end
          end
        ST_COMP: begin
          b <= b + ADDR_W'(1);
          if (b == ADDR_W'(H - 1)) begin
            state <= ST_DRAIN;
            d <= '0;
          end
        end
        ST_DRAIN: begin
          d <= d + DW'(1);
          if (d == DW'(PIPE_LAT - 1)) begin
            s <= s + LOG2N'(1);
            p <= '0;
            state <= s == LOG2N'(LOG2N - 1) ? ST_OUT : ST_COMP;
          end
        end
        ST_OUT: begin
          p <= p + ADDR_W'(1);
          if (p == ADDR_W'(H - 1)) begin
            state <= ST_IDLE;
            load_done <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: doc/fft_inplace_sequencer.md
Name: fft_inplace_sequencer

Overview:
Control sequencer for the in-place radix-2 DIT FFT core with two single-read/single-write SRAM banks. It loads N input samples in bit-reversed order across the two banks and issues LOG2N stages of N/2 butterfly read/write address pairs. It also drives the swap-unit controls, the twiddle index and the result readout, and sits between the top-level start/valid handshake and the butterfly datapath.

Parameters:
LOG2N, 5, log2 of FFT length N (N=32 at default).
ADDR_W, LOG2N-1, per-bank address width; each bank holds N/2 words.
PIPE_LAT, 2, cycles from read issue to write-back of the same butterfly (SRAM read 1 plus multiplier register 1).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  begin a transform; sampled only in IDLE
valid  in  1  input sample present on datapath this cycle (LOAD only)
busy  out  1  high in every state except IDLE
load_done  out  1  datapath input-mux select: 0 = external samples, 1 = butterfly results
load_bank  out  1  input demux select: bank receiving the current sample
we_b0, we_b1  out  1 each  bank write enables
re_b0, re_b1  out  1 each  bank read enables
waddr_b0, waddr_b1  out  ADDR_W each  bank write addresses
raddr_b0, raddr_b1  out  ADDR_W each  bank read addresses
swap_rd  out  1  read-side swap: 1 = upper operand comes from bank1
swap_wr  out  1  write-side swap: swap_rd delayed by PIPE_LAT
tw_idx  out  LOG2N-1  twiddle ROM index, aligned with the read issue
out_valid  out  1  result pair present (bank0/bank1 order after swap_rd)
done  out  1  one-cycle pulse coinciding with the last out_valid

Behaviour:
- Memory map: logical index i maps to bank = XOR of all bits of i (parity) and address = i>>1. Both butterfly operands and both output-pair indices always differ in exactly one bit, so they always sit in opposite banks.
- Reset: state IDLE. All outputs are 0, including counters and pipeline delay lines. Reset asserted in any state aborts the transform that cycle. Bank contents are not cleared.
- IDLE: start=1 moves to LOAD. All enables are 0.
- LOAD: sample counter k counts 0..N-1 and advances only when valid=1. Target index j = bitrev_LOG2N(k). load_bank = parity(j). The selected bank gets we=1 and waddr = j>>1; the other bank gets we=0. Cycles with valid=0 write nothing. After the write of k=N-1, go to COMP and drive load_done=1.
- COMP: stage counter s counts 0..LOG2N-1; butterfly counter b counts 0..N/2-1 with one issue per cycle.
  - Upper index u = b with a 0 inserted at bit s; lower index l = u | (1<<s).
  - Both re=1. The raddr of bank parity(u) is u>>1 and the other raddr is l>>1. swap_rd = parity(u).
  - tw_idx = (b mod 2^s) << (LOG2N-1-s).
  - Each issue is delayed PIPE_LAT cycles and then produces we_b0=we_b1=1, with the waddrs equal to the delayed raddrs and swap_wr set.
  - After b=N/2-1, go to DRAIN.
- DRAIN: PIPE_LAT cycles with no reads while the in-flight writes complete (read-after-write hazard between stages). Then return to COMP with s+1, or go to OUT after the last stage. COMP+DRAIN takes LOG2N*(N/2+PIPE_LAT) cycles (90 at default).
- OUT: pair counter p counts 0..N/2-1. Read indices 2p and 2p+1. Bank parity(2p) gets raddr p, the other bank also gets raddr p, and swap_rd = parity(2p). out_valid follows each read by 1 cycle. done pulses with the out_valid for p=N/2-1. Next state is IDLE; load_done clears on entry to IDLE.
- start outside IDLE is ignored. valid outside LOAD is ignored.
- All write strobes are registered. No combinational path from start or valid to any output except through state.

Decomposition:
- Shared package holds LOG2N and PIPE_LAT defaults, the state encoding (IDLE, LOAD, COMP, DRAIN, OUT) and functions for bitrev, parity and zero-bit-insert.
- Natural sub-module: fft_wb_delay, a PIPE_LAT-deep shift register carrying {we, waddr_b0, waddr_b1, swap}.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, busy=0. Assert rst mid-COMP (s=2) -> next cycle IDLE, we/re=0, done never fires.
- start, then sample k=1 with valid -> we_b1=1, waddr_b1=8, load_bank=1. Insert valid=0 gaps -> no writes, k holds.
- COMP s=0: b=0 -> raddr_b0=0, raddr_b1=0, swap_rd=0. b=1 -> raddr_b1=1, raddr_b0=1, swap_rd=1. Writes appear 2 cycles later with matching waddr and swap_wr.
- COMP s=2, b=5 -> u=9 (bank0, raddr_b0=4), l=13 (bank1, raddr_b1=6), tw_idx=4. After b=15 -> 2 idle DRAIN cycles before s=3 begins.
- Full run with continuous valid -> exactly 90 cycles from COMP entry to OUT entry, 16 out_valid cycles, done coincident with the last one, then busy=0.
- start pulsed during LOAD and during OUT -> no restart, counters unaffected.
